cam_yuv_capture: RTL and testbench

- Capture front-end for the OV7670 parallel port. Sits directly upstream of the green/colour detectors and the framebuffer write port.
- Samples the 8-bit YUV422 byte stream on PCLK, framed by VSYNC/HREF, and assembles each 4-byte group into one pixel pair (Y, Y_2, Cb, Cr).
- Each pair is emitted with a one-cycle valid pulse, a linear framebuffer address (CONTADOR_C), and frame/line status.

---
 rtl/cam_pkg.sv | 32 +++
 rtl/cam_yuv_capture_if.sv | 34 +++
 rtl/cam_sync_edge.sv | 50 +++++
 rtl/cam_yuv_capture.sv | 202 ++++++++++++++++++++
 tb/tb_cam_yuv_capture.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the OV7670 capture front-end and its neighbours
// (framebuffer, VGA stage): default frame geometry, capture FSM states,
// YUV422 byte-phase constants and the test-pattern luma helper.
// -----------------------------------------------------------------------------
package cam_pkg;

  // Default active frame geometry, shared with the framebuffer and VGA stage.
  localparam int CAM_WIDTH  = 640;
  localparam int CAM_HEIGHT = 480;
  localparam int CAM_ADDR_W = 19;   // 2**19 >= 640*480

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    BLANK,
    ACTIVE
  } cam_state_e;

  // Position of a byte inside one Y0,Cb,Y1,Cr group.
  localparam logic [1:0] PH_Y0 = 2'd0;
  localparam logic [1:0] PH_CB = 2'd1;
  localparam logic [1:0] PH_Y1 = 2'd2;
  localparam logic [1:0] PH_CR = 2'd3;

  // Greyscale bar level for one of the eight test-pattern bars.
  function automatic logic [7:0] bar_luma(input logic [2:0] bar);
    return {bar, 5'b0};
  endfunction

endpackage

// File: rtl/cam_yuv_capture_if.sv
// -----------------------------------------------------------------------------
// cam_yuv_capture_if
// Pixel-pair output bus of the capture front-end.
//   Y, Y_2, Cb, Cr : pixel pair (even luma, odd luma, shared chroma)
//   e_pix          : one-cycle strobe, pair and CONTADOR_C valid
//   CONTADOR_C     : linear framebuffer address of the even pixel
//   frame_done     : one-cycle strobe at the end of a captured frame
//   line_err       : sticky line length / line count error
// Modports: master = capture block (drives), slave = consumer.
// -----------------------------------------------------------------------------
interface cam_yuv_capture_if
  import cam_pkg::*;
#(
  parameter int ADDR_W = CAM_ADDR_W
) ();

  logic [7:0]        Y;
  logic [7:0]        Y_2;
  logic [7:0]        Cb;
  logic [7:0]        Cr;
  logic              e_pix;
  logic [ADDR_W-1:0] CONTADOR_C;
  logic              frame_done;
  logic              line_err;

  modport master (
    output Y, Y_2, Cb, Cr, e_pix, CONTADOR_C, frame_done, line_err
  );

  modport slave (
    input Y, Y_2, Cb, Cr, e_pix, CONTADOR_C, frame_done, line_err
  );

endinterface

// File: rtl/cam_sync_edge.sv
// -----------------------------------------------------------------------------
// cam_sync_edge
// Registers the camera VSYNC/HREF once and derives edge strobes from the
// registered copies.
//   PCLK, reset  : pixel clock, synchronous active-high reset
//   i_vsync      : camera VSYNC          o_vsync     : registered VSYNC
//   i_href       : camera HREF           o_href      : registered HREF
//   o_vs_rise    : registered VSYNC 0->1 o_vs_fall   : registered VSYNC 1->0
//   o_href_fall  : registered HREF 1->0
// -----------------------------------------------------------------------------
module cam_sync_edge (
  input  logic PCLK,
  input  logic reset,
  input  logic i_vsync,
  input  logic i_href,
  output logic o_vsync,
  output logic o_href,
  output logic o_vs_rise,
  output logic o_vs_fall,
  output logic o_href_fall
);

  logic r_vsync;
  logic r_vsync_d;
  logic r_href;
  logic r_href_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge PCLK) begin
    if (reset) begin
      r_vsync   <= 1'b0;
      r_vsync_d <= 1'b0;
      r_href    <= 1'b0;
      r_href_d  <= 1'b0;
    end else begin
      r_vsync   <= i_vsync;
      r_vsync_d <= r_vsync;
      r_href    <= i_href;
      r_href_d  <= r_href;
    end
  end

  assign o_vsync     = r_vsync;
  assign o_href      = r_href;
  assign o_vs_rise   =  r_vsync & ~r_vsync_d;
  assign o_vs_fall   = ~r_vsync &  r_vsync_d;
  assign o_href_fall = ~r_href  &  r_href_d;

endmodule

// File: rtl/cam_yuv_capture.sv
// -----------------------------------------------------------------------------
// cam_yuv_capture
// OV7670 parallel-port capture front-end. Samples the YUV422 byte stream
// (Y0, Cb, Y1, Cr) framed by VSYNC/HREF and emits one pixel pair per group
// with a linear framebuffer address. Capture is armed by capture_en and only
// starts at a frame boundary (VSYNC rise, then fall).
//   PCLK, reset      : pixel clock, synchronous active-high reset
//   VSYNC, HREF, D   : camera frame/line strobes and data byte
//   capture_en       : arm capture (honoured at frame boundaries)
//   test_mode        : present only with CAM_CAPTURE_TEST_PATTERN_EN; selects
//                      internal greyscale bars instead of D
//   pix              : pixel-pair output bus (master side)
// Optional feature macro: CAM_CAPTURE_TEST_PATTERN_EN
// -----------------------------------------------------------------------------
module cam_yuv_capture
  import cam_pkg::*;
#(
  parameter int WIDTH  = CAM_WIDTH,
  parameter int HEIGHT = CAM_HEIGHT,
  parameter int ADDR_W = CAM_ADDR_W
) (
  input  logic       PCLK,
  input  logic       reset,
  input  logic       VSYNC,
  input  logic       HREF,
  input  logic [7:0] D,
  input  logic       capture_en,
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  cam_yuv_capture_if.master pix
);

  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int LC_W  = $clog2(HEIGHT + 1);
  localparam int BC_W  = $clog2(2 * WIDTH + 1) + 1;  // headroom to see overlong lines

  logic w_vsync, w_href, w_vs_rise, w_vs_fall, w_href_fall;

  cam_sync_edge u_sync (
    .PCLK        (PCLK),
    .reset       (reset),
    .i_vsync     (VSYNC),
    .i_href      (HREF),
    .o_vsync     (w_vsync),
    .o_href      (w_href),
    .o_vs_rise   (w_vs_rise),
    .o_vs_fall   (w_vs_fall),
    .o_href_fall (w_href_fall)
  );

  cam_state_e        r_state;
  logic [7:0]        r_d;
  logic [1:0]        r_phase;
  logic [BC_W-1:0]   r_byte_cnt;
  logic [COL_W-1:0]  r_col;
  logic [LC_W-1:0]   r_line_cnt;
  logic [ADDR_W-1:0] r_line_base;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_y0_hold, r_cb_hold, r_y1_hold;
  logic [7:0]        r_y, r_y_2, r_cb, r_cr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_e_pix, r_frame_done, r_line_err;

  logic [7:0]        w_byte;
  logic              w_take, w_pair_ok, w_line_close, w_line_room;
  logic [LC_W-1:0]   w_lines_end;

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
  // Bars follow the even-pixel column of the pair being assembled, so both
  // lumas of a pair share one bar; chroma is neutral grey.
  logic [2:0] w_bar;
  logic [7:0] w_pat;
  assign w_bar  = 3'(32'(r_col) >> 7);
  assign w_pat  = (r_phase == PH_Y0 || r_phase == PH_Y1) ? bar_luma(w_bar) : 8'h80;
  assign w_byte = test_mode ? w_pat : r_d;
`else
  assign w_byte = r_d;
`endif

  // Bytes seen while VSYNC is high are blanking garbage and never assembled.
  assign w_take       = (r_state == ACTIVE) && w_href && !w_vsync;
  assign w_line_room  = r_line_cnt < LC_W'(HEIGHT);
  assign w_pair_ok    = (r_col < COL_W'(WIDTH)) && w_line_room;
  assign w_line_close = (r_state == ACTIVE) && w_href_fall;
  // Line count as it stands after a line closing on this same edge, so a
  // coincident VSYNC rise judges the frame with that line included.
  assign w_lines_end  = (w_line_close && w_line_room) ? r_line_cnt + LC_W'(1) : r_line_cnt;

  always_ff @(posedge PCLK) begin
    if (reset) begin
      r_state      <= IDLE;
      r_d          <= '0;
      r_phase      <= PH_Y0;
      r_byte_cnt   <= '0;
      r_col        <= '0;
      r_line_cnt   <= '0;
      r_line_base  <= '0;
      r_ptr        <= '0;
      r_y0_hold    <= '0;
      r_cb_hold    <= '0;
      r_y1_hold    <= '0;
      r_y          <= '0;
      r_y_2        <= '0;
      r_cb         <= '0;
      r_cr         <= '0;
      r_addr       <= '0;
      r_e_pix      <= 1'b0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
    end else begin
      r_d          <= D;
      // NOTE: strobes default low each cycle and are raised only where they
      // fire, giving exact one-cycle pulses without extra clear logic.
      r_e_pix      <= 1'b0;
      r_frame_done <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (capture_en) r_state <= SYNC;
        end

        SYNC: begin
          if (w_vs_rise) r_state <= BLANK;
        end

        BLANK: begin
          if (w_vs_fall) begin
            r_line_cnt  <= '0;
            r_line_base <= '0;
            r_ptr       <= '0;
            r_col       <= '0;
            r_byte_cnt  <= '0;
            r_phase     <= PH_Y0;
            r_line_err  <= 1'b0;
            r_state     <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (w_take) begin
            if (r_byte_cnt != '1) r_byte_cnt <= r_byte_cnt + 1'b1;
            r_phase <= r_phase + 2'd1;
            case (r_phase)
              PH_Y0:   r_y0_hold <= w_byte;
              PH_CB:   r_cb_hold <= w_byte;
              PH_Y1:   r_y1_hold <= w_byte;
              default: begin
                if (w_pair_ok) begin
                  r_y     <= r_y0_hold;
                  r_cb    <= r_cb_hold;
                  r_y_2   <= r_y1_hold;
                  r_cr    <= w_byte;
                  r_addr  <= r_ptr;
                  r_e_pix <= 1'b1;
                  r_ptr   <= r_ptr + ADDR_W'(2);
                  r_col   <= r_col + COL_W'(2);
                end else begin
                  // Pair past the end of the line or below the last line.
                  r_line_err <= 1'b1;
                end
              end
            endcase
          end

          // End of line: length check, drop any partial group, step to the
          // next line base by addition. Line count saturates at HEIGHT so the
          // base never runs past the frame.
          if (w_line_close) begin
            if (r_byte_cnt != BC_W'(2 * WIDTH)) r_line_err <= 1'b1;
            r_phase    <= PH_Y0;
            r_byte_cnt <= '0;
            r_col      <= '0;
            if (w_line_room) begin
              r_line_cnt  <= r_line_cnt + LC_W'(1);
              r_line_base <= r_line_base + ADDR_W'(WIDTH);
              r_ptr       <= r_line_base + ADDR_W'(WIDTH);
            end
          end

          if (w_vs_rise) begin
            r_frame_done <= 1'b1;
            if (w_lines_end != LC_W'(HEIGHT)) r_line_err <= 1'b1;
            r_state <= capture_en ? BLANK : IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign pix.Y          = r_y;
  assign pix.Y_2        = r_y_2;
  assign pix.Cb         = r_cb;
  assign pix.Cr         = r_cr;
  assign pix.e_pix      = r_e_pix;
  assign pix.CONTADOR_C = r_addr;
  assign pix.frame_done = r_frame_done;
  assign pix.line_err   = r_line_err;

endmodule

// File: tb/tb_cam_yuv_capture.sv
// -----------------------------------------------------------------------------
// tb_cam_yuv_capture
// Directed bench for cam_yuv_capture using a 4x4 frame. Stimulus is driven on
// the falling edge; a monitor samples the pixel bus 1 time unit after each
// rising edge and logs every pair with its cycle number.
// With CAM_CAPTURE_TEST_PATTERN_EN a second, default-geometry instance runs
// with test_mode = 1 on the same stimulus.
// -----------------------------------------------------------------------------
module tb_cam_yuv_capture;
  import cam_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 5;

  logic       PCLK = 1'b0;
  logic       reset = 1'b1;
  logic       VSYNC = 1'b0;
  logic       HREF = 1'b0;
  logic [7:0] D = 8'd0;
  logic       capture_en = 1'b0;

  always #5 PCLK = ~PCLK;

  cam_yuv_capture_if #(.ADDR_W(AW)) pix ();

  cam_yuv_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) u_dut (
    .PCLK       (PCLK),
    .reset      (reset),
    .VSYNC      (VSYNC),
    .HREF       (HREF),
    .D          (D),
    .capture_en (capture_en),
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    .test_mode  (1'b0),
`endif
    .pix        (pix)
  );

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
  cam_yuv_capture_if pix_tp ();

  cam_yuv_capture u_tp (
    .PCLK       (PCLK),
    .reset      (reset),
    .VSYNC      (VSYNC),
    .HREF       (HREF),
    .D          (D),
    .capture_en (capture_en),
    .test_mode  (1'b1),
    .pix        (pix_tp)
  );
`endif

  typedef struct {
    int         cyc;
    int         addr;
    logic [7:0] y, y2, cb, cr;
  } ev_t;

  ev_t ev_q[$];
  ev_t tp_q[$];
  int  cyc    = 0;
  int  fd_cnt = 0;

  always @(posedge PCLK) begin : monitor
    ev_t e;
    #1;
    cyc++;
    if (pix.e_pix === 1'b1) begin
      e.cyc = cyc; e.addr = int'(pix.CONTADOR_C);
      e.y = pix.Y; e.y2 = pix.Y_2; e.cb = pix.Cb; e.cr = pix.Cr;
      ev_q.push_back(e);
    end
    if (pix.frame_done === 1'b1) fd_cnt++;
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    if (pix_tp.e_pix === 1'b1) begin
      e.cyc = cyc; e.addr = int'(pix_tp.CONTADOR_C);
      e.y = pix_tp.Y; e.y2 = pix_tp.Y_2; e.cb = pix_tp.Cb; e.cr = pix_tp.Cr;
      tp_q.push_back(e);
    end
`endif
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [7:0] pat [4] = '{8'd10, 8'd20, 8'd11, 8'd30};
  int         last_cr_cyc = 0;

  task automatic tick(input logic v, input logic h, input logic [7:0] d);
    @(negedge PCLK);
    VSYNC = v;
    HREF  = h;
    D     = d;
  endtask

  task automatic vs_rise();
    repeat (4) tick(1'b1, 1'b0, 8'd0);
  endtask

  task automatic vs_fall();
    repeat (4) tick(1'b0, 1'b0, 8'd0);
  endtask

  // One line of nbytes from the 10,20,11,30 pattern plus 4 blank cycles;
  // capture_en is raised after byte arm_at (negative: never).
  task automatic send_line(input int nbytes, input int arm_at);
    for (int i = 0; i < nbytes; i++) begin
      tick(1'b0, 1'b1, pat[i % 4]);
      if (i == arm_at) capture_en = 1'b1;
      if (i == 3) last_cr_cyc = cyc;
    end
    repeat (4) tick(1'b0, 1'b0, 8'd0);
  endtask

  task automatic send_lines(input int n);
    for (int l = 0; l < n; l++) send_line(2 * W, -1);
  endtask

  task automatic check_pair(input string tag, input int idx, input int exp_addr);
    check({tag, "_addr"}, 64'(ev_q[idx].addr), 64'(exp_addr));
    check({tag, "_data"}, {ev_q[idx].y, ev_q[idx].cb, ev_q[idx].y2, ev_q[idx].cr},
          {8'd10, 8'd20, 8'd11, 8'd30});
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pix"},   {pix.Y, pix.Y_2, pix.Cb, pix.Cr}, 32'd0);
    check({tag, "_addr"},  pix.CONTADOR_C, '0);
    check({tag, "_flags"}, {pix.e_pix, pix.frame_done, pix.line_err}, 3'b000);
  endtask

  int base, fd0, lat, max_addr;
  int exp3 [7] = '{0, 2, 4, 8, 10, 12, 14};

  initial begin
    // ------------------------------------------------------------ reset
    repeat (3) @(negedge PCLK);
    check_zero_outputs("rst");
    reset = 1'b0;
    capture_en = 1'b1;
    vs_fall();

    // ------------------------------------------------- T1: nominal frame
    base = ev_q.size(); fd0 = fd_cnt;
    vs_rise();
    vs_fall();
    send_line(2 * W, -1);
    lat = last_cr_cyc;
    send_lines(H - 1);
    vs_rise();
    check("t1_pairs", 64'(ev_q.size() - base), 64'd8);
    check("t1_frame_done", 64'(fd_cnt - fd0), 64'd1);
    check("t1_line_err", pix.line_err, 1'b0);
    check("t1_latency", 64'(ev_q[base].cyc), 64'(lat + 2));
    for (int i = 0; i < 8; i++) check_pair($sformatf("t1_p%0d", i), base + i, 2 * i);
    vs_fall();

    // -------------------------------------- T2: armed in the middle of a frame
    @(negedge PCLK); reset = 1'b1; capture_en = 1'b0;
    @(negedge PCLK); reset = 1'b0;
    base = ev_q.size(); fd0 = fd_cnt;
    send_line(2 * W, -1);
    send_line(2 * W, 3);
    send_line(2 * W, -1);
    vs_rise();
    check("t2_no_pix_before_fall", 64'(ev_q.size() - base), 64'd0);
    check("t2_no_frame_done", 64'(fd_cnt - fd0), 64'd0);
    vs_fall();
    send_lines(H);
    vs_rise();
    check("t2_pairs", 64'(ev_q.size() - base), 64'd8);
    check_pair("t2_first", base, 0);
    check("t2_frame_done", 64'(fd_cnt - fd0), 64'd1);
    check("t2_line_err", pix.line_err, 1'b0);
    vs_fall();

    // ------------------------------------------------ T3: short second line
    base = ev_q.size(); fd0 = fd_cnt;
    send_line(2 * W, -1);
    send_line(6, -1);
    check("t3_line_err_set", pix.line_err, 1'b1);
    send_lines(2);
    vs_rise();
    check("t3_line_err_held", pix.line_err, 1'b1);
    check("t3_pairs", 64'(ev_q.size() - base), 64'd7);
    check("t3_frame_done", 64'(fd_cnt - fd0), 64'd1);
    for (int i = 0; i < 7; i++) check_pair($sformatf("t3_p%0d", i), base + i, exp3[i]);
    vs_fall();
    check("t3_line_err_cleared", pix.line_err, 1'b0);

    // ----------------------------------------------- T4: HEIGHT+1 lines
    base = ev_q.size(); fd0 = fd_cnt;
    send_lines(H);
    check("t4_line_err_before_extra", pix.line_err, 1'b0);
    send_line(2 * W, -1);
    check("t4_line_err_extra", pix.line_err, 1'b1);
    vs_rise();
    check("t4_pairs", 64'(ev_q.size() - base), 64'd8);
    max_addr = 0;
    for (int i = base; i < ev_q.size(); i++)
      if (ev_q[i].addr > max_addr) max_addr = ev_q[i].addr;
    check("t4_max_addr", 64'(max_addr), 64'(W * H - 2));
    check("t4_frame_done", 64'(fd_cnt - fd0), 64'd1);
    vs_fall();

    // -------------------------------------------- T5: reset in mid-line
    send_line(2 * W, -1);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, pat[i % 4]);
    check("t5_addr_before_reset", pix.CONTADOR_C, AW'(4));
    tick(1'b0, 1'b1, pat[2]);
    reset = 1'b1;
    tick(1'b0, 1'b1, pat[3]);
    reset = 1'b0;
    check_zero_outputs("t5_after_reset");
    fd0 = fd_cnt;
    repeat (4) tick(1'b0, 1'b0, 8'd0);
    send_lines(2);
    vs_rise();
    check("t5_no_frame_done", 64'(fd_cnt - fd0), 64'd0);
    vs_fall();
    base = ev_q.size();
    send_lines(H);
    vs_rise();
    check("t5_pairs", 64'(ev_q.size() - base), 64'd8);
    check_pair("t5_first", base, 0);
    check("t5_frame_done", 64'(fd_cnt - fd0), 64'd1);
    vs_fall();

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    // ------------------------------------ T6: internal greyscale bars
    begin
      int tp_base;
      tp_base = tp_q.size();
      base    = ev_q.size();
      send_line(264, -1);
      check("t6_tp_pairs", 64'(tp_q.size() - tp_base), 64'd66);
      check("t6_timing", 64'(tp_q[tp_base].cyc), 64'(ev_q[base].cyc));
      check("t6_col0", {tp_q[tp_base].y, tp_q[tp_base].y2, tp_q[tp_base].cb, tp_q[tp_base].cr},
            32'h0000_8080);
      check("t6_col128_addr", 64'(tp_q[tp_base + 64].addr), 64'd128);
      check("t6_col128", {tp_q[tp_base + 64].y, tp_q[tp_base + 64].y2,
                          tp_q[tp_base + 64].cb, tp_q[tp_base + 64].cr}, 32'h2020_8080);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
